// File: rtl/mba_module.sv
// Pipelined 8x8 radix-4 modified-Booth multiplier.
//
// Ports:
//   clock  - rising-edge clock for all registers
//   rst_n  - asynchronous active-low reset; clears operand and product registers
//   a      - 8-bit multiplicand
//   b      - 8-bit multiplier, Booth-recoded
//   p      - 16-bit registered product, valid two rising edges after a/b are sampled
//
// Configuration:
//   MBA_UNSIGNED_EN - when defined, a and b are unsigned (b zero-extended to 10 bits giving
//                     5 Booth digits, a zero-extended to 9 bits). When undefined, a and b are
//                     signed two's complement and b yields 4 Booth digits.
module mba_module (
  input  logic        clock,
  input  logic        rst_n,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);

`ifdef MBA_UNSIGNED_EN
  localparam int unsigned NumDigits = 5;
`else
  localparam int unsigned NumDigits = 4;
`endif
  localparam int unsigned BExtW = 2 * NumDigits;

  typedef struct packed {
    logic [3:0] s;
    logic       g;
    logic       p;
  } cla4_t;

  // 4-bit carry-lookahead block: sum plus group generate/propagate.
  function automatic cla4_t cla4(input logic [3:0] x, input logic [3:0] y, input logic ci);
    logic [3:0] g;
    logic [3:0] pr;
    logic [3:0] c;
    cla4_t      r;
    g    = x & y;
    pr   = x ^ y;
    c[0] = ci;
    c[1] = g[0] | (pr[0] & ci);
    c[2] = g[1] | (pr[1] & g[0]) | (pr[1] & pr[0] & ci);
    c[3] = g[2] | (pr[2] & g[1]) | (pr[2] & pr[1] & g[0]) | (pr[2] & pr[1] & pr[0] & ci);
    r.s  = pr ^ c;
    r.g  = g[3] | (pr[3] & g[2]) | (pr[3] & pr[2] & g[1]) | (pr[3] & pr[2] & pr[1] & g[0]);
    r.p  = &pr;
    return r;
  endfunction

  // 16-bit adder: four CLA blocks joined by a second-level lookahead unit, so no carry ripples
  // across the full width. Group g/p do not depend on carry-in, hence the two passes.
  function automatic logic [15:0] cla16(input logic [15:0] x, input logic [15:0] y);
    cla4_t       blk;
    logic [3:0]  gg;
    logic [3:0]  gp;
    logic [3:0]  gc;
    logic [15:0] s;
    for (int k = 0; k < 4; k++) begin
      blk   = cla4(x[4*k +: 4], y[4*k +: 4], 1'b0);
      gg[k] = blk.g;
      gp[k] = blk.p;
    end
    gc[0] = 1'b0;
    gc[1] = gg[0];
    gc[2] = gg[1] | (gp[1] & gg[0]);
    gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]);
    for (int k = 0; k < 4; k++) begin
      blk          = cla4(x[4*k +: 4], y[4*k +: 4], gc[k]);
      s[4*k +: 4]  = blk.s;
    end
    return s;
  endfunction

  logic [7:0]  a_r_q, a_r_d;
  logic [7:0]  b_r_q, b_r_d;
  logic [15:0] p_q, p_d;

  logic [8:0]           a_ext;
  logic [BExtW:0]       b_ext;  // bit 0 is the implicit b[-1] = 0
  logic [2:0]           trip  [NumDigits];
  logic [9:0]           mag   [NumDigits];
  logic [9:0]           mag_x [NumDigits];
  logic [15:0]          pp    [NumDigits];
  logic [NumDigits-1:0] neg;
  logic [NumDigits-1:0] one;
  logic [NumDigits-1:0] two;
  logic [15:0]          corr;
  logic [15:0]          acc;

  always_comb begin
    a_r_d = a;
    b_r_d = b;
  end

  // Operand extension and Booth recoding.
  always_comb begin
`ifdef MBA_UNSIGNED_EN
    a_ext = {1'b0, a_r_q};
    b_ext = {2'b00, b_r_q, 1'b0};
`else
    a_ext = {a_r_q[7], a_r_q};
    b_ext = {b_r_q, 1'b0};
`endif
    corr = '0;
    for (int i = 0; i < NumDigits; i++) begin
      trip[i] = b_ext[2*i +: 3];
      neg[i]  = trip[i][2];
      one[i]  = trip[i][1] ^ trip[i][0];
      two[i]  = (trip[i] == 3'b100) || (trip[i] == 3'b011);
      if (one[i]) begin
        mag[i] = {a_ext[8], a_ext};
      end else if (two[i]) begin
        mag[i] = {a_ext, 1'b0};
      end else begin
        mag[i] = '0;
      end
      // Negative digits use one's complement here; the +1 lands in corr at the digit's weight.
      mag_x[i] = neg[i] ? ~mag[i] : mag[i];
      pp[i]    = {{6{mag_x[i][9]}}, mag_x[i]} << (2 * i);
      corr[2*i] = neg[i];
    end
  end

  // Partial product accumulation.
  always_comb begin
    acc = corr;
    for (int i = 0; i < NumDigits; i++) begin
      acc = cla16(acc, pp[i]);
    end
    p_d = acc;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      a_r_q <= '0;
      b_r_q <= '0;
      p_q   <= '0;
    end else begin
      a_r_q <= a_r_d;
      b_r_q <= b_r_d;
      p_q   <= p_d;
    end
  end

  assign p = p_q;

endmodule

// File: tb/tb_mba_module.sv
// Self-checking bench for mba_module: scoreboard of expected products, directed cases, async
// reset behaviour and a sweep of all operand pairs. Honours MBA_UNSIGNED_EN like the design.
module tb_mba_module;

  logic        clock;
  logic        rst_n;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [15:0] p;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] sb_q[$];
  string       tag_q[$];

  mba_module dut (
    .clock (clock),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .p     (p)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_prod(input logic [7:0] x, input logic [7:0] y);
    logic [15:0] r;
`ifdef MBA_UNSIGNED_EN
    r = {8'd0, x} * {8'd0, y};
`else
    r = $signed({{8{x[7]}}, x}) * $signed({{8{y[7]}}, y});
`endif
    return r;
  endfunction

  // One cycle: compare the result issued two cycles ago, then drive new operands.
  task automatic step(input logic [7:0] x, input logic [7:0] y, input logic [15:0] exp,
                      input string tag);
    @(negedge clock);
    if (sb_q.size() == 2) check_eq(tag_q.pop_front(), p, sb_q.pop_front());
    a = x;
    b = y;
    sb_q.push_back(exp);
    tag_q.push_back(tag);
  endtask

  task automatic drain();
    while (sb_q.size() > 0) begin
      @(negedge clock);
      check_eq(tag_q.pop_front(), p, sb_q.pop_front());
    end
  endtask

  // After reset the pipeline holds 0*0 in both stages.
  task automatic prime_zero();
    sb_q.delete();
    tag_q.delete();
    sb_q.push_back(16'h0000);
    tag_q.push_back("pipe_zero0");
    sb_q.push_back(16'h0000);
    tag_q.push_back("pipe_zero1");
  endtask

  initial begin
    rst_n = 1'b0;
    a     = '0;
    b     = '0;
    @(negedge clock);
    check_eq("reset_p", p, 16'h0000);
    rst_n = 1'b1;
    prime_zero();

`ifdef MBA_UNSIGNED_EN
    step(8'd255, 8'd255, 16'hFE01, "u_255x255");
    step(8'd128, 8'd2,   16'h0100, "u_128x2");
    step(8'd50,  8'd50,  16'h09C4, "u_50x50");
`else
    step(8'd50,  8'd50,  16'h09C4, "basic_50x50");
    step(8'h80,  8'h80,  16'h4000, "s_m128xm128");
    step(8'hFF,  8'h01,  16'hFFFF, "s_m1x1");
    step(8'h7F,  8'h80,  16'hC080, "s_127xm128");
    step(8'd3,   8'd4,   16'h000C, "pipe_3x4");
    step(8'd5,   8'd6,   16'h001E, "pipe_5x6");
    step(8'd7,   8'hF8,  16'hFFC8, "pipe_7xm8");
`endif
    drain();

    // Asynchronous reset between edges while p holds 2500.
    step(8'd50, 8'd50, 16'h09C4, "pre_rst0");
    step(8'd50, 8'd50, 16'h09C4, "pre_rst1");
    step(8'd50, 8'd50, 16'h09C4, "pre_rst2");
    #2;
    rst_n = 1'b0;
    a     = '0;
    b     = '0;
    #1;
    check_eq("rst_async_p", p, 16'h0000);
    #1;
    rst_n = 1'b1;
    prime_zero();
    step(8'd10, 8'd10, 16'h0064, "post_rst_10x10");
    drain();

    for (int i = 0; i < 65536; i++) begin
      logic [15:0] ab;
      ab = i[15:0];
      step(ab[15:8], ab[7:0], ref_prod(ab[15:8], ab[7:0]),
           $sformatf("sweep a=0x%02h b=0x%02h", ab[15:8], ab[7:0]));
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
